// File: rtl/cycle_timer.sv
// Prescaled down-counting run timer with pause, abort, retrigger and auto-reload.
// All outputs come straight from registers; the next-state logic sits in one comb block.
module cycle_timer #(
  parameter int WIDTH    = 8,
  parameter int PRESCALE = 1000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] duration,
  input  logic             pause,
  input  logic             abort,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done,
  output logic [1:0]       state
);

  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_MAX = PS_W'(PRESCALE - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    RUN    = 2'b01,
    PAUSED = 2'b10
  } state_t;

  state_t            st, st_nxt;
  logic [PS_W-1:0]   ps, ps_nxt;
  logic [WIDTH-1:0]  rl, rl_nxt;
  logic [WIDTH-1:0]  count_nxt;
  logic              done_nxt;

  function automatic logic [WIDTH-1:0] dec_sat(input logic [WIDTH-1:0] v);
    return (v == '0) ? '0 : v - 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      st    <= IDLE;
      count <= '0;
      ps    <= '0;
      rl    <= '0;
      done  <= 1'b0;
      busy  <= 1'b0;
    end else begin
      st    <= st_nxt;
      count <= count_nxt;
      ps    <= ps_nxt;
      rl    <= rl_nxt;
      done  <= done_nxt;
      busy  <= (st_nxt != IDLE);
    end
  end

  always_comb begin
    st_nxt    = st;
    count_nxt = count;
    ps_nxt    = ps;
    rl_nxt    = rl;
    done_nxt  = 1'b0;
    if (abort) begin
      // abort always swallows a coincident start, even when already idle
      if (st != IDLE) begin
        st_nxt    = IDLE;
        count_nxt = '0;
        ps_nxt    = '0;
      end
    end else if (start) begin
      count_nxt = duration;
      rl_nxt    = duration;
      ps_nxt    = '0;
      if (duration != '0) begin
        st_nxt = RUN;
      end else begin
        st_nxt   = IDLE;
        done_nxt = 1'b1;
      end
    end else if (st != IDLE) begin
      if (pause) begin
        st_nxt = PAUSED;
      end else begin
        // leaving PAUSED counts this edge, so a pause of N cycles delays expiry by exactly N
        st_nxt = RUN;
        if (ps == PS_MAX) begin
          ps_nxt = '0;
          if (count == WIDTH'(1)) begin
            done_nxt = 1'b1;
            if (auto_reload) begin
              count_nxt = rl;
            end else begin
              count_nxt = '0;
              st_nxt    = IDLE;
            end
          end else if (count == '0) begin
            st_nxt = IDLE;
          end else begin
            count_nxt = dec_sat(count);
          end
        end else begin
          ps_nxt = ps + 1'b1;
        end
      end
    end
  end

  assign state = st;

endmodule

// File: tb/tb_cycle_timer.sv
// Bench for cycle_timer (WIDTH=8, PRESCALE=4): directed stimulus pushes hand-derived
// per-edge expectations into a queue; a negedge monitor pops and compares them.
module tb_cycle_timer;

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_RUN  = 2'b01;
  localparam logic [1:0] S_PAU  = 2'b10;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [7:0] duration = '0;
  logic       pause = 1'b0;
  logic       abort = 1'b0;
  logic       auto_reload = 1'b0;
  logic [7:0] count;
  logic       busy;
  logic       done;
  logic [1:0] state;

  typedef struct {
    logic [7:0] c;
    logic       b;
    logic       d;
    logic [1:0] s;
    string      tag;
  } exp_t;

  exp_t  q[$];
  int    n_chk = 0;
  int    n_fail = 0;
  string tag = "reset";

  cycle_timer #(.WIDTH(8), .PRESCALE(4)) dut (
    .clk(clk), .reset(reset), .start(start), .duration(duration),
    .pause(pause), .abort(abort), .auto_reload(auto_reload),
    .count(count), .busy(busy), .done(done), .state(state)
  );

  always #5 clk = ~clk;

  // one expectation per rising edge; each is checked at the following falling edge
  task automatic cyc(input int n, input logic [7:0] c, input logic d, input logic [1:0] s);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      e.c = c; e.b = (s != S_IDLE); e.d = d; e.s = s; e.tag = tag;
      q.push_back(e);
    end
  endtask

  task automatic kick(input logic [7:0] dur);
    start = 1'b1;
    duration = dur;
    cyc(1, (dur == 0) ? 8'd0 : dur, (dur == 0), (dur == 0) ? S_IDLE : S_RUN);
    start = 1'b0;
  endtask

  always @(negedge clk) begin
    if (q.size() != 0) begin
      exp_t e;
      e = q.pop_front();
      n_chk++;
      if (count !== e.c || busy !== e.b || done !== e.d || state !== e.s) begin
        n_fail++;
        $display("FAIL %s: got count=%0d busy=%b done=%b state=%b, expected count=%0d busy=%b done=%b state=%b",
                 e.tag, count, busy, done, state, e.c, e.b, e.d, e.s);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    cyc(2, 8'd0, 1'b0, S_IDLE);
    reset = 1'b0;
    tag = "idle_after_reset";
    cyc(2, 8'd0, 1'b0, S_IDLE);

    // duration 3: ticks on edges 4, 8, 12; done on 12
    tag = "basic_d3";
    kick(8'd3);
    cyc(3, 8'd3, 1'b0, S_RUN);
    cyc(4, 8'd2, 1'b0, S_RUN);
    cyc(4, 8'd1, 1'b0, S_RUN);
    cyc(1, 8'd0, 1'b1, S_IDLE);
    cyc(2, 8'd0, 1'b0, S_IDLE);

    // duration 2, pause sampled high on edges 3..7: done on edge 13
    tag = "pause_d2";
    kick(8'd2);
    cyc(2, 8'd2, 1'b0, S_RUN);
    pause = 1'b1;
    cyc(5, 8'd2, 1'b0, S_PAU);
    pause = 1'b0;
    cyc(1, 8'd2, 1'b0, S_RUN);
    cyc(4, 8'd1, 1'b0, S_RUN);
    cyc(1, 8'd0, 1'b1, S_IDLE);
    cyc(1, 8'd0, 1'b0, S_IDLE);

    // pause on the edge that would tick suppresses it; expiry slips by one edge
    tag = "pause_on_tick";
    kick(8'd1);
    cyc(3, 8'd1, 1'b0, S_RUN);
    pause = 1'b1;
    cyc(1, 8'd1, 1'b0, S_PAU);
    pause = 1'b0;
    cyc(1, 8'd0, 1'b1, S_IDLE);
    cyc(1, 8'd0, 1'b0, S_IDLE);

    // auto-reload duration 2: done on edges 8, 16, 24, busy throughout
    tag = "auto_reload";
    auto_reload = 1'b1;
    kick(8'd2);
    cyc(3, 8'd2, 1'b0, S_RUN);
    for (int k = 0; k < 3; k++) begin
      cyc(4, 8'd1, 1'b0, S_RUN);
      cyc(1, 8'd2, 1'b1, S_RUN);
      cyc(3, 8'd2, 1'b0, S_RUN);
    end
    tag = "abort_reload_run";
    abort = 1'b1;
    cyc(1, 8'd0, 1'b0, S_IDLE);
    abort = 1'b0;
    tag = "idle_ignores_pause_reload";
    pause = 1'b1;
    cyc(3, 8'd0, 1'b0, S_IDLE);
    pause = 1'b0;
    auto_reload = 1'b0;

    // duration 5, abort at edge 6
    tag = "abort_d5";
    kick(8'd5);
    cyc(3, 8'd5, 1'b0, S_RUN);
    cyc(2, 8'd4, 1'b0, S_RUN);
    abort = 1'b1;
    cyc(1, 8'd0, 1'b0, S_IDLE);
    abort = 1'b0;
    cyc(10, 8'd0, 1'b0, S_IDLE);

    // zero-length run
    tag = "zero_len";
    kick(8'd0);
    cyc(2, 8'd0, 1'b0, S_IDLE);

    // retrigger with 4 at edge 5 of a duration-3 run: done on edge 21
    tag = "retrigger";
    kick(8'd3);
    cyc(3, 8'd3, 1'b0, S_RUN);
    cyc(1, 8'd2, 1'b0, S_RUN);
    kick(8'd4);
    cyc(3, 8'd4, 1'b0, S_RUN);
    cyc(4, 8'd3, 1'b0, S_RUN);
    cyc(4, 8'd2, 1'b0, S_RUN);
    cyc(4, 8'd1, 1'b0, S_RUN);
    cyc(1, 8'd0, 1'b1, S_IDLE);
    cyc(1, 8'd0, 1'b0, S_IDLE);

    // reset at edge 7 of a duration-3 run; no done and no resumption
    tag = "reset_mid_run";
    kick(8'd3);
    cyc(3, 8'd3, 1'b0, S_RUN);
    cyc(3, 8'd2, 1'b0, S_RUN);
    reset = 1'b1;
    cyc(1, 8'd0, 1'b0, S_IDLE);
    reset = 1'b0;
    cyc(12, 8'd0, 1'b0, S_IDLE);

    // start+abort on the same edge, from IDLE and from RUN
    tag = "start_abort_idle";
    start = 1'b1; abort = 1'b1; duration = 8'd5;
    cyc(1, 8'd0, 1'b0, S_IDLE);
    start = 1'b0; abort = 1'b0;
    cyc(2, 8'd0, 1'b0, S_IDLE);
    tag = "start_abort_run";
    kick(8'd3);
    start = 1'b1; abort = 1'b1; duration = 8'd7;
    cyc(1, 8'd0, 1'b0, S_IDLE);
    start = 1'b0; abort = 1'b0;
    cyc(6, 8'd0, 1'b0, S_IDLE);

    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL: %0d expectations never checked", q.size());
    end
    if (n_chk < 12) begin
      n_fail++;
      $display("FAIL: only %0d checks evaluated", n_chk);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    if (n_fail == 0) begin
      $display("PASS");
    end else begin
      $display("FAIL: %0d mismatches", n_fail);
    end
    $finish;
  end

endmodule

// File: doc/cycle_timer.md
CYCLE_TIMER -- requirements
Module: cycle_timer

Interface
REQ-001 SHALL provide parameter WIDTH, default 8, bit width of duration and remaining count.
REQ-002 SHALL provide parameter PRESCALE, default 1000, clk cycles per count tick; SHALL be 1 or greater.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  load duration and begin or retrigger a run.
REQ-006 duration  input  WIDTH  tick count for the run, sampled only when start=1.
REQ-007 pause  input  1  level; while high, the run is frozen.
REQ-008 abort  input  1  cancel the current run without a done pulse.
REQ-009 auto_reload  input  1  mode; when 1 at expiry, reload the latched duration and keep running.
REQ-010 count  output  WIDTH  remaining ticks.
REQ-011 busy  output  1  high in RUN or PAUSED.
REQ-012 done  output  1  one-cycle expiry pulse.
REQ-013 state  output  2  state code: IDLE=00, RUN=01, PAUSED=10.

Function
REQ-014 SHALL implement the states IDLE, RUN and PAUSED, with a prescaler counter ps (0..PRESCALE-1) and a reload register rl (WIDTH bits).
REQ-015 Per-edge priority SHALL be: reset > abort > start > pause/resume > tick.
REQ-016 start=1 with duration!=0, in any state: count<=duration, rl<=duration, ps<=0, state<=RUN.
REQ-017 start=1 with duration==0: state<=IDLE, count<=0, done<=1 on the next edge (zero-length run).
REQ-018 In RUN with pause=0, ps SHALL increment each cycle; at ps==PRESCALE-1, ps<=0 and count<=count-1 (a tick).
REQ-019 A tick taking count from 1 to 0 (expiry) SHALL register done=1 for exactly one cycle.
REQ-020 At expiry with auto_reload=1: count<=rl, ps<=0, remain in RUN, no idle cycle.
REQ-021 At expiry with auto_reload=0: count<=0, state<=IDLE.
REQ-022 Latency: with duration=D, no pause and auto_reload=0, done SHALL rise on the D*PRESCALE-th edge after the edge sampling start.
REQ-023 In RUN, pause=1 SHALL move to PAUSED on that edge with no ps increment that cycle.
REQ-024 In PAUSED, ps and count SHALL hold; pause=0 SHALL return to RUN, and counting resumes the following cycle.
REQ-025 A pause asserted on the cycle a tick would occur SHALL suppress that tick, so no time is lost or gained.
REQ-026 abort=1 in RUN or PAUSED: state<=IDLE, count<=0, ps<=0, done=0; abort in IDLE SHALL have no effect.
REQ-027 start and abort on the same edge: abort SHALL win and start SHALL be ignored.
REQ-028 In IDLE, pause and auto_reload SHALL have no effect.
REQ-029 count SHALL never wrap below 0.
REQ-030 With PRESCALE=1, a tick SHALL occur every RUN cycle.
REQ-031 done and busy SHALL be registered outputs; no combinational input-to-output path SHALL exist.

Reset
REQ-032 reset=1 SHALL force state=IDLE, count=0, ps=0, rl=0, busy=0, done=0 on the next edge, overriding all inputs.
REQ-033 reset asserted mid-run SHALL abandon the run with no done pulse; operation SHALL resume only by a new start.

Verification (WIDTH=8, PRESCALE=4)
REQ-034 start, duration=3, auto_reload=0 -> count steps 3,2,1,0 every 4 cycles; done high one cycle on edge 12; busy low from edge 12.
REQ-035 duration=2 run, pause high for 5 cycles at edge 3 -> done on edge 13; count holds at 2 while paused.
REQ-036 duration=2, auto_reload=1 held -> done pulses on edges 8, 16 and 24; busy stays 1 throughout; count reloads to 2.
REQ-037 duration=5 run, abort at edge 6 -> state=IDLE, count=0, no done thereafter.
REQ-038 start with duration=0 -> done pulse next edge, busy remains 0; start with duration=4 at edge 5 of a duration=3 run -> count=4 and done on edge 21.
REQ-039 reset at edge 7 of a duration=3 run -> all outputs 0 on the next edge, no done; same-edge start+abort leaves IDLE.
